// File: rtl/cnn_pkg.sv
// Shared widths, kernel and FSM encoding for the digit classifier.
package cnn_pkg;

    localparam int DEF_IMG_W   = 28;
    localparam int DEF_IMG_H   = 28;
    localparam int ADDR_W      = 10;
    localparam int PIX_W       = 8;
    localparam int ACC_W       = 12;
    localparam int RELU_W      = 10;
    localparam int SCORE_W     = 16;
    localparam int NUM_CLASSES = 10;

    typedef logic [PIX_W-1:0]          pix_t;
    typedef logic signed [ACC_W-1:0]   acc_t;
    typedef logic [RELU_W-1:0]         relu_t;
    typedef logic [SCORE_W-1:0]        score_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ARGMAX,
        S_DONE
    } state_t;

    // Sobel-x, indexed [ky][kx]
    localparam logic signed [2:0] KERNEL [3][3] = '{
        '{-3'sd1, 3'sd0, 3'sd1},
        '{-3'sd2, 3'sd0, 3'sd2},
        '{-3'sd1, 3'sd0, 3'sd1}
    };

endpackage

// File: rtl/cnn_digit_if.sv
// Start / image-load / LED bundle between the host side and the classifier.
interface cnn_digit_if;
    import cnn_pkg::*;

    logic              start;
    logic              tb_write_en;
    logic [ADDR_W-1:0] tb_write_addr;
    pix_t              tb_write_data;
    logic [7:0]        led_out;

    modport master (
        output start, tb_write_en, tb_write_addr, tb_write_data,
        input  led_out
    );

    modport slave (
        input  start, tb_write_en, tb_write_addr, tb_write_data,
        output led_out
    );

endinterface

// File: rtl/image_bram.sv
// Image store: one synchronous write port, one read port with 1-cycle latency.
module image_bram
    import cnn_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_W * DEF_IMG_H
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  pix_t              i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output pix_t              o_rdata
);

    pix_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/cnn_digit_top.sv
// Fixed-weight CNN: Sobel-x conv, ReLU, 2x2 maxpool, 10-class sum, argmax.
module cnn_digit_top
    import cnn_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic        clk,
    input  logic        reset,
    cnn_digit_if.slave  bus
);

    localparam int PW    = (IMG_W - 2) / 2;
    localparam int PH    = (IMG_H - 2) / 2;
    localparam int DEPTH = IMG_W * IMG_H;

    state_t      r_state;
    logic        r_start_d;
    logic [7:0]  r_led;
    logic [3:0]  r_px, r_py, r_cls;
    logic [1:0]  r_s, r_kx, r_ky;
    logic        r_issue_done;
    logic        r_d_vld, r_d_first, r_d_last;
    logic        r_d_sfirst, r_d_slast, r_d_end;
    logic [1:0]  r_d_kx, r_d_ky;
    logic [3:0]  r_d_cls;
    acc_t        r_acc;
    relu_t       r_pool;
    score_t      r_score [NUM_CLASSES];
    logic [3:0]  r_am_idx, r_best;
    score_t      r_best_val;

    logic              w_busy, w_start_rise, w_we;
    logic [ADDR_W-1:0] w_x, w_y, w_raddr;
    logic              w_tap_last, w_cell_last, w_all_last;
    pix_t              w_rdata;
    logic signed [2:0] w_k;
    acc_t              w_pix, w_wt, w_acc_nxt;
    relu_t             w_relu, w_pool_nxt;
    logic              w_am_gt;
    logic [3:0]        w_best_nxt;

    assign w_busy       = (r_state == S_RUN) || (r_state == S_ARGMAX);
    assign w_start_rise = bus.start & ~r_start_d;
    assign w_we         = bus.tb_write_en & ~w_busy
                        & (bus.tb_write_addr < ADDR_W'(DEPTH));

    assign w_x = ADDR_W'({r_px, 1'b0}) + ADDR_W'(r_s[0]) + ADDR_W'(r_kx);
    assign w_y = ADDR_W'({r_py, 1'b0}) + ADDR_W'(r_s[1]) + ADDR_W'(r_ky);
    assign w_raddr = w_y * ADDR_W'(IMG_W) + w_x;

    assign w_tap_last  = (r_kx == 2'd2) && (r_ky == 2'd2);
    assign w_cell_last = w_tap_last && (r_s == 2'd3);
    assign w_all_last  = w_cell_last && (r_px == 4'(PW - 1))
                       && (r_py == 4'(PH - 1));

    image_bram #(.DEPTH(DEPTH)) u_bram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (bus.tb_write_addr),
        .i_wdata (bus.tb_write_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // MAC consumes the pixel read one cycle earlier, steered by the delayed tap flags
    assign w_k        = KERNEL[r_d_ky][r_d_kx];
    assign w_pix      = acc_t'({4'b0, w_rdata});
    assign w_wt       = acc_t'(w_k);
    assign w_acc_nxt  = (r_d_first ? '0 : r_acc) + w_pix * w_wt;
    assign w_relu     = w_acc_nxt[ACC_W-1] ? '0 : w_acc_nxt[RELU_W-1:0];
    assign w_pool_nxt = (r_d_sfirst || (w_relu > r_pool)) ? w_relu : r_pool;

    assign w_am_gt    = r_score[r_am_idx] > r_best_val;
    assign w_best_nxt = w_am_gt ? r_am_idx : r_best;

    assign bus.led_out = r_led;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_px         <= '0;
            r_py         <= '0;
            r_s          <= '0;
            r_kx         <= '0;
            r_ky         <= '0;
            r_cls        <= '0;
            r_issue_done <= 1'b0;
            r_d_vld      <= 1'b0;
            r_d_first    <= 1'b0;
            r_d_last     <= 1'b0;
            r_d_sfirst   <= 1'b0;
            r_d_slast    <= 1'b0;
            r_d_end      <= 1'b0;
            r_d_kx       <= '0;
            r_d_ky       <= '0;
            r_d_cls      <= '0;
        end else begin
            r_d_vld <= 1'b0;
            if (r_state != S_RUN) begin
                r_px         <= '0;
                r_py         <= '0;
                r_s          <= '0;
                r_kx         <= '0;
                r_ky         <= '0;
                r_cls        <= '0;
                r_issue_done <= 1'b0;
            end else if (!r_issue_done) begin
                r_d_vld    <= 1'b1;
                r_d_first  <= (r_kx == 2'd0) && (r_ky == 2'd0);
                r_d_last   <= w_tap_last;
                r_d_sfirst <= (r_s == 2'd0);
                r_d_slast  <= (r_s == 2'd3);
                r_d_end    <= w_all_last;
                r_d_kx     <= r_kx;
                r_d_ky     <= r_ky;
                r_d_cls    <= r_cls;
                if (r_kx != 2'd2) begin
                    r_kx <= r_kx + 2'd1;
                end else begin
                    r_kx <= '0;
                    if (r_ky != 2'd2) begin
                        r_ky <= r_ky + 2'd1;
                    end else begin
                        r_ky <= '0;
                        r_s  <= r_s + 2'd1;
                        if (r_s == 2'd3) begin
                            r_cls <= (r_cls == 4'(NUM_CLASSES - 1))
                                   ? '0 : r_cls + 4'd1;
                            if (r_px != 4'(PW - 1)) begin
                                r_px <= r_px + 4'd1;
                            end else begin
                                r_px <= '0;
                                if (r_py != 4'(PH - 1))
                                    r_py <= r_py + 4'd1;
                                else
                                    r_issue_done <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_start_d  <= 1'b0;
            r_led      <= 8'h00;
            r_acc      <= '0;
            r_pool     <= '0;
            r_am_idx   <= '0;
            r_best     <= '0;
            r_best_val <= '0;
            for (int i = 0; i < NUM_CLASSES; i++)
                r_score[i] <= '0;
        end else begin
            r_start_d <= bus.start;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_rise) begin
                        r_state <= S_RUN;
                        r_led   <= 8'h40;
                        for (int i = 0; i < NUM_CLASSES; i++)
                            r_score[i] <= '0;
                    end
                end
                S_RUN: begin
                    if (r_d_vld) begin
                        r_acc <= w_acc_nxt;
                        if (r_d_last) begin
                            r_pool <= w_pool_nxt;
                            if (r_d_slast)
                                r_score[r_d_cls] <= r_score[r_d_cls]
                                                  + score_t'(w_pool_nxt);
                        end
                        if (r_d_end) begin
                            r_state    <= S_ARGMAX;
                            r_am_idx   <= '0;
                            r_best     <= '0;
                            r_best_val <= '0;
                        end
                    end
                end
                S_ARGMAX: begin
                    // strict '>' so ties keep the lowest class
                    if (w_am_gt) begin
                        r_best     <= r_am_idx;
                        r_best_val <= r_score[r_am_idx];
                    end
                    r_am_idx <= r_am_idx + 4'd1;
                    if (r_am_idx == 4'(NUM_CLASSES - 1)) begin
                        r_state <= S_DONE;
                        r_led   <= {1'b1, 1'b0, 2'b00, w_best_nxt};
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_digit_top.sv
// Directed bench for cnn_digit_top with an expected-LED scoreboard and a behavioural model.
module tb_cnn_digit_top;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cnn_digit_if dif ();

    cnn_digit_top dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         img [784];
    logic [7:0] sb [$];

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    function automatic int pix(int x, int y);
        return img[y * 28 + x];
    endfunction

    // Sobel-x written out as column differences, independent of any kernel table
    function automatic logic [3:0] model_class();
        int score [10];
        int best, bv, pool, c, cx, cy;
        foreach (score[i]) score[i] = 0;
        for (int py = 0; py < 13; py++) begin
            for (int px = 0; px < 13; px++) begin
                pool = 0;
                for (int dy = 0; dy < 2; dy++) begin
                    for (int dx = 0; dx < 2; dx++) begin
                        cx = 2 * px + dx;
                        cy = 2 * py + dy;
                        c = (pix(cx + 2, cy) - pix(cx, cy))
                          + 2 * (pix(cx + 2, cy + 1) - pix(cx, cy + 1))
                          + (pix(cx + 2, cy + 2) - pix(cx, cy + 2));
                        if (c < 0) c = 0;
                        if (c > pool) pool = c;
                    end
                end
                score[(py * 13 + px) % 10] += pool;
            end
        end
        best = 0;
        bv   = score[0];
        for (int i = 1; i < 10; i++) begin
            if (score[i] > bv) begin
                bv   = score[i];
                best = i;
            end
        end
        return 4'(best);
    endfunction

    task automatic load_img();
        for (int a = 0; a < 784; a++) begin
            @(negedge clk);
            dif.tb_write_en   = 1'b1;
            dif.tb_write_addr = 10'(a);
            dif.tb_write_data = 8'(img[a]);
        end
        @(negedge clk);
        dif.tb_write_en = 1'b0;
    endtask

    task automatic run(input string tag, input logic [7:0] exp,
                       input bit disturb);
        int         cyc;
        logic [7:0] e;
        sb.push_back(exp);
        @(negedge clk);
        dif.start = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        check({tag, "_busy"}, dif.led_out, 8'h40);
        cyc = 1;
        while (dif.led_out[7] !== 1'b1 && cyc < 7000) begin
            @(negedge clk);
            cyc++;
            if (disturb) begin
                dif.start         = ((cyc % 700) == 5);
                dif.tb_write_en   = (cyc == 30);
                dif.tb_write_addr = 10'(1 * 28 + 18);
                dif.tb_write_data = 8'd255;
            end
        end
        dif.start       = 1'b0;
        dif.tb_write_en = 1'b0;
        n_tests++;
        assert (cyc < 7000) else begin
            n_fail++;
            $error("FAIL %s_latency: observed=%0d cycles expected<7000",
                   tag, cyc);
        end
        e = sb.pop_front();
        check({tag, "_led"}, dif.led_out, e);
    endtask

    initial begin
        logic [7:0] exp_g;
        reset             = 1'b1;
        dif.start         = 1'b0;
        dif.tb_write_en   = 1'b0;
        dif.tb_write_addr = '0;
        dif.tb_write_data = '0;

        repeat (3) @(negedge clk);
        check("reset_during", dif.led_out, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        check("reset_after", dif.led_out, 8'h00);

        foreach (img[i]) img[i] = 0;
        load_img();
        repeat (20) @(negedge clk);
        check("idle_no_start", dif.led_out, 8'h00);
        run("zero", 8'h80, 1'b0);

        foreach (img[i]) img[i] = 255;
        load_img();
        run("uniform255", 8'h80, 1'b0);

        foreach (img[i]) img[i] = 0;
        img[1 * 28 + 8] = 100;
        load_img();
        run("single_px", 8'h83, 1'b0);
        run("busy_pulses", 8'h83, 1'b1);
        repeat (5) @(negedge clk);
        check("done_hold", dif.led_out, 8'h83);
        run("restart_done", 8'h83, 1'b0);

        for (int y = 0; y < 28; y++)
            for (int x = 0; x < 28; x++)
                img[y * 28 + x] = (x * 8 + y * 4 > 255) ? 255 : x * 8 + y * 4;
        load_img();
        exp_g = {4'h8, model_class()};
        run("gradient", exp_g, 1'b0);
        run("gradient_rerun", exp_g, 1'b0);

        @(negedge clk);
        dif.start = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (1000) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_midrun", dif.led_out, 8'h00);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("after_abort", dif.led_out, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
